// File: rtl/dt_arbiter_anasymod_if.sv
// Timestep-request bus between the oscillator/analog models, run control and dt_arbiter_anasymod.
// DT_ARB_STEP_CNT_EN adds the step counter and winner-index signals.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

interface dt_arbiter_anasymod_if #(
  parameter int N_REQ      = 4,
  parameter int DT_WIDTH   = `DT_WIDTH,
  parameter int TIME_WIDTH = 40
);
  localparam int WIN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ*DT_WIDTH-1:0] __emu_dt_req;
  logic [DT_WIDTH-1:0]       __emu_dt;
  logic [TIME_WIDTH-1:0]     emu_time;
  logic [1:0]                emu_ctrl_mode;
  logic [TIME_WIDTH-1:0]     emu_ctrl_data;
  logic [2:0]                emu_state;
  logic                      emu_stopped;
`ifdef DT_ARB_STEP_CNT_EN
  logic [31:0]               emu_step_cnt;
  logic [WIN_W-1:0]          emu_req_winner;
`endif

  modport master (
    output __emu_dt_req, emu_ctrl_mode, emu_ctrl_data,
    input  __emu_dt, emu_time, emu_state, emu_stopped
`ifdef DT_ARB_STEP_CNT_EN
    , input emu_step_cnt, emu_req_winner
`endif
  );

  modport slave (
    input  __emu_dt_req, emu_ctrl_mode, emu_ctrl_data,
    output __emu_dt, emu_time, emu_state, emu_stopped
`ifdef DT_ARB_STEP_CNT_EN
    , output emu_step_cnt, emu_req_winner
`endif
  );
endinterface

// File: rtl/dt_arbiter_anasymod.sv
// Global timestep arbiter: grants min(request, DT_MAX) under run control and accumulates emulation time.
// Optional DT_ARB_STEP_CNT_EN adds a saturating step counter and a registered winner index.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

module dt_arbiter_anasymod #(
  parameter int                  N_REQ      = 4,
  parameter int                  DT_WIDTH   = `DT_WIDTH,
  parameter int                  TIME_WIDTH = 40,
  parameter logic [DT_WIDTH-1:0] DT_MAX     = {DT_WIDTH{1'b1}}
) (
  input logic                  __emu_clk,
  input logic                  __emu_rst,
  dt_arbiter_anasymod_if.slave bus
);
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_PAUSE     = 3'd1,
    ST_STOP_WAIT = 3'd2,
    ST_STOP_HIT  = 3'd3,
    ST_STEP_ARM  = 3'd4,
    ST_STEP_DONE = 3'd5
  } state_t;

  localparam logic [1:0] M_RUN   = 2'd0;
  localparam logic [1:0] M_PAUSE = 2'd1;
  localparam logic [1:0] M_STOP  = 2'd2;
  localparam logic [1:0] M_STEP  = 2'd3;

  state_t                state;
  logic [1:0]            prev_mode;
  logic [TIME_WIDTH-1:0] emu_time;
  logic                  stopped;

  logic [DT_WIDTH-1:0]   min_req, dt_cand, dt_stop, dt;
  logic [TIME_WIDTH-1:0] remaining;
  logic                  hit;

  always_comb begin
    min_req = bus.__emu_dt_req[DT_WIDTH-1:0];
    for (int i = 1; i < N_REQ; i++)
      if (bus.__emu_dt_req[i*DT_WIDTH +: DT_WIDTH] < min_req)
        min_req = bus.__emu_dt_req[i*DT_WIDTH +: DT_WIDTH];
    dt_cand = (min_req > DT_MAX) ? DT_MAX : min_req;
  end

  // Mode is applied in the same cycle it changes; state only refines it for stop/step handling.
  always_comb begin
    remaining = bus.emu_ctrl_data - emu_time;
    dt_stop   = '0;
    if (emu_time < bus.emu_ctrl_data)
      dt_stop = (TIME_WIDTH'(dt_cand) <= remaining) ? dt_cand : remaining[DT_WIDTH-1:0];
    dt = '0;
    if (!__emu_rst) begin
      case (bus.emu_ctrl_mode)
        M_RUN:   dt = dt_cand;
        M_PAUSE: dt = '0;
        M_STOP:  dt = (state == ST_STOP_HIT) ? '0 : dt_stop;
        default: dt = (state == ST_STEP_ARM) ? dt_cand : '0;
      endcase
    end
  end

  assign hit = ({1'b0, emu_time} + (TIME_WIDTH+1)'(dt)) >= {1'b0, bus.emu_ctrl_data};

  always_ff @(posedge __emu_clk or posedge __emu_rst) begin
    if (__emu_rst) begin
      state     <= ST_RUN;
      prev_mode <= M_RUN;
      emu_time  <= '0;
      stopped   <= 1'b0;
    end else begin
      prev_mode <= bus.emu_ctrl_mode;
      emu_time  <= emu_time + TIME_WIDTH'(dt);
      stopped   <= 1'b0;
      case (bus.emu_ctrl_mode)
        M_RUN:   state <= ST_RUN;
        M_PAUSE: state <= ST_PAUSE;
        M_STOP: begin
          state   <= hit ? ST_STOP_HIT : ST_STOP_WAIT;
          stopped <= hit;
        end
        default: begin
          // A fresh entry into single-step arms one step; it then parks until the mode changes.
          if (prev_mode != M_STEP) state <= ST_STEP_ARM;
          else                     state <= ST_STEP_DONE;
        end
      endcase
    end
  end

  assign bus.__emu_dt    = dt;
  assign bus.emu_time    = emu_time;
  assign bus.emu_state   = state;
  assign bus.emu_stopped = stopped;

`ifdef DT_ARB_STEP_CNT_EN
  localparam int WIN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [31:0]      step_cnt;
  logic [WIN_W-1:0] winner, win_nxt;
  logic             win_hit;

  always_comb begin
    win_nxt = '0;
    win_hit = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.__emu_dt_req[i*DT_WIDTH +: DT_WIDTH] == dt) begin
        win_nxt = WIN_W'(i);
        win_hit = 1'b1;
      end
  end

  // Winner holds its last value on cycles where the grant was clamped below every request.
  always_ff @(posedge __emu_clk or posedge __emu_rst) begin
    if (__emu_rst) begin
      step_cnt <= '0;
      winner   <= '0;
    end else begin
      if (dt != '0 && step_cnt != 32'hFFFF_FFFF) step_cnt <= step_cnt + 32'd1;
      if (win_hit) winner <= win_nxt;
    end
  end

  assign bus.emu_step_cnt   = step_cnt;
  assign bus.emu_req_winner = winner;
`endif
endmodule

// File: tb/tb_dt_arbiter_anasymod.sv
// Directed bench for dt_arbiter_anasymod: default, DT_MAX=5 and TIME_WIDTH=8 instances on one clock.
`ifndef DT_WIDTH
`define DT_WIDTH 16
`endif

module tb_dt_arbiter_anasymod;
  localparam int DW = `DT_WIDTH;

  logic __emu_clk = 1'b0;
  logic __emu_rst = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 __emu_clk = ~__emu_clk;

  dt_arbiter_anasymod_if #(.N_REQ(4), .DT_WIDTH(DW), .TIME_WIDTH(40)) m ();
  dt_arbiter_anasymod_if #(.N_REQ(4), .DT_WIDTH(DW), .TIME_WIDTH(40)) d ();
  dt_arbiter_anasymod_if #(.N_REQ(4), .DT_WIDTH(8),  .TIME_WIDTH(8))  w ();

  dt_arbiter_anasymod #(.N_REQ(4), .DT_WIDTH(DW), .TIME_WIDTH(40)) u_m (
    .__emu_clk(__emu_clk), .__emu_rst(__emu_rst), .bus(m));
  dt_arbiter_anasymod #(.N_REQ(4), .DT_WIDTH(DW), .TIME_WIDTH(40), .DT_MAX(DW'(5))) u_d (
    .__emu_clk(__emu_clk), .__emu_rst(__emu_rst), .bus(d));
  dt_arbiter_anasymod #(.N_REQ(4), .DT_WIDTH(8), .TIME_WIDTH(8)) u_w (
    .__emu_clk(__emu_clk), .__emu_rst(__emu_rst), .bus(w));

  task automatic tick;
    @(posedge __emu_clk);
    #1;
  endtask

  task automatic do_reset;
    tick();
    __emu_rst = 1'b1;
    #2;
    __emu_rst = 1'b0;
  endtask

  task automatic set_m(input int r0, input int r1, input int r2, input int r3);
    m.__emu_dt_req = {DW'(r3), DW'(r2), DW'(r1), DW'(r0)};
  endtask

  task automatic test_reset;
    m.emu_ctrl_mode = 2'd0; m.emu_ctrl_data = '0;
    d.emu_ctrl_mode = 2'd1; d.emu_ctrl_data = '0;
    w.emu_ctrl_mode = 2'd1; w.emu_ctrl_data = '0;
    set_m(10, 7, 12, 7);
    d.__emu_dt_req = '0;
    w.__emu_dt_req = '0;
    #1 __emu_rst = 1'b1;
    #1;
    checks++; if (m.__emu_dt !== DW'(0)) begin failures++; $display("FAIL reset_dt got=%0d exp=0", m.__emu_dt); end
    checks++; if (m.emu_time !== 40'd0) begin failures++; $display("FAIL reset_time got=%0d exp=0", m.emu_time); end
    checks++; if (m.emu_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", m.emu_state); end
    checks++; if (m.emu_stopped !== 1'b0) begin failures++; $display("FAIL reset_stopped got=%0d exp=0", m.emu_stopped); end
    tick();
    __emu_rst = 1'b0;
  endtask

  task automatic test_min_grant;
    logic [3:0] g;
    #1;
    checks++; if (m.__emu_dt !== DW'(7)) begin failures++; $display("FAIL min_dt got=%0d exp=7", m.__emu_dt); end
    for (int i = 0; i < 4; i++) g[i] = (m.__emu_dt_req[i*DW +: DW] == m.__emu_dt);
    checks++; if (g !== 4'b1010) begin failures++; $display("FAIL min_grant_mask got=%b exp=1010", g); end
    tick();
    checks++; if (m.emu_time !== 40'd7) begin failures++; $display("FAIL min_time got=%0d exp=7", m.emu_time); end
    set_m(5, 0, 9, 2);
    #1;
    checks++; if (m.__emu_dt !== DW'(0)) begin failures++; $display("FAIL zero_req_dt got=%0d exp=0", m.__emu_dt); end
    tick();
    checks++; if (m.emu_time !== 40'd7) begin failures++; $display("FAIL zero_req_time got=%0d exp=7", m.emu_time); end
    set_m(20, 30, 15, 40);
    #1;
    checks++; if (m.__emu_dt !== DW'(15)) begin failures++; $display("FAIL min2_dt got=%0d exp=15", m.__emu_dt); end
    tick();
    checks++; if (m.emu_time !== 40'd22) begin failures++; $display("FAIL min2_time got=%0d exp=22", m.emu_time); end
  endtask

  task automatic test_dt_max;
    do_reset();
    d.__emu_dt_req = {DW'(6), DW'(20), DW'(8), DW'(9)};
    d.emu_ctrl_mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (d.__emu_dt !== DW'(5)) begin failures++; $display("FAIL dtmax_dt[%0d] got=%0d exp=5", k, d.__emu_dt); end
      checks++; if (d.emu_time !== 40'(5*k)) begin failures++; $display("FAIL dtmax_time[%0d] got=%0d exp=%0d", k, d.emu_time, 5*k); end
      tick();
    end
    d.emu_ctrl_mode = 2'd1;
  endtask

  task automatic test_stop_at;
    int exp_dt[5]   = '{7, 7, 6, 0, 0};
    int exp_tm[5]   = '{0, 7, 14, 20, 20};
    int exp_stp[5]  = '{0, 0, 0, 1, 1};
    do_reset();
    set_m(7, 7, 7, 7);
    m.emu_ctrl_data = 40'd20;
    m.emu_ctrl_mode = 2'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (m.__emu_dt !== DW'(exp_dt[k])) begin failures++; $display("FAIL stop_dt[%0d] got=%0d exp=%0d", k, m.__emu_dt, exp_dt[k]); end
      checks++; if (m.emu_time !== 40'(exp_tm[k])) begin failures++; $display("FAIL stop_time[%0d] got=%0d exp=%0d", k, m.emu_time, exp_tm[k]); end
      checks++; if (m.emu_stopped !== 1'(exp_stp[k])) begin failures++; $display("FAIL stop_flag[%0d] got=%0d exp=%0d", k, m.emu_stopped, exp_stp[k]); end
      tick();
    end
    checks++; if (m.emu_state !== 3'd3) begin failures++; $display("FAIL stop_hit_state got=%0d exp=3", m.emu_state); end
    m.emu_ctrl_data = 40'd30;
    #1;
    checks++; if (m.__emu_dt !== DW'(0)) begin failures++; $display("FAIL stop_retarget_dt got=%0d exp=0", m.__emu_dt); end
    tick();
    #1;
    checks++; if (m.emu_state !== 3'd2) begin failures++; $display("FAIL stop_rewait_state got=%0d exp=2", m.emu_state); end
    checks++; if (m.emu_stopped !== 1'b0) begin failures++; $display("FAIL stop_rewait_flag got=%0d exp=0", m.emu_stopped); end
    checks++; if (m.__emu_dt !== DW'(7)) begin failures++; $display("FAIL stop_rewait_dt got=%0d exp=7", m.__emu_dt); end
  endtask

  task automatic test_pause;
    do_reset();
    set_m(7, 7, 7, 7);
    m.emu_ctrl_mode = 2'd0;
    tick();
    tick();
    checks++; if (m.emu_time !== 40'd14) begin failures++; $display("FAIL pause_pre_time got=%0d exp=14", m.emu_time); end
    m.emu_ctrl_mode = 2'd1;
    #1;
    checks++; if (m.__emu_dt !== DW'(0)) begin failures++; $display("FAIL pause_dt got=%0d exp=0", m.__emu_dt); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (m.emu_time !== 40'd14) begin failures++; $display("FAIL pause_time[%0d] got=%0d exp=14", k, m.emu_time); end
    end
    m.emu_ctrl_mode = 2'd0;
    #1;
    checks++; if (m.__emu_dt !== DW'(7)) begin failures++; $display("FAIL resume_dt got=%0d exp=7", m.__emu_dt); end
    tick();
    checks++; if (m.emu_time !== 40'd21) begin failures++; $display("FAIL resume_time got=%0d exp=21", m.emu_time); end
  endtask

  task automatic test_single_step;
    int n;
    do_reset();
    set_m(4, 4, 4, 4);
    m.emu_ctrl_mode = 2'd1;
    tick();
    m.emu_ctrl_mode = 2'd3;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      #1 if (m.__emu_dt != '0) n++;
      tick();
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL step1_count got=%0d exp=1", n); end
    checks++; if (m.emu_time !== 40'd4) begin failures++; $display("FAIL step1_time got=%0d exp=4", m.emu_time); end
    checks++; if (m.emu_state !== 3'd5) begin failures++; $display("FAIL step1_state got=%0d exp=5", m.emu_state); end
    m.emu_ctrl_mode = 2'd1;
    tick();
    m.emu_ctrl_mode = 2'd3;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      #1 if (m.__emu_dt != '0) n++;
      tick();
    end
    checks++; if (n !== 1) begin failures++; $display("FAIL step2_count got=%0d exp=1", n); end
    checks++; if (m.emu_time !== 40'd8) begin failures++; $display("FAIL step2_time got=%0d exp=8", m.emu_time); end
  endtask

  task automatic test_wrap;
    do_reset();
    w.__emu_dt_req = {4{8'd250}};
    w.emu_ctrl_mode = 2'd0;
    #1;
    checks++; if (w.__emu_dt !== 8'd250) begin failures++; $display("FAIL wrap_dt1 got=%0d exp=250", w.__emu_dt); end
    tick();
    checks++; if (w.emu_time !== 8'd250) begin failures++; $display("FAIL wrap_time1 got=%0d exp=250", w.emu_time); end
    w.__emu_dt_req = {4{8'd10}};
    tick();
    checks++; if (w.emu_time !== 8'd4) begin failures++; $display("FAIL wrap_time2 got=%0d exp=4", w.emu_time); end
    w.emu_ctrl_mode = 2'd1;
  endtask

  task automatic test_async_reset;
    do_reset();
    set_m(7, 7, 7, 7);
    m.emu_ctrl_mode = 2'd0;
    tick();
    checks++; if (m.emu_time !== 40'd7) begin failures++; $display("FAIL arst_pre_time got=%0d exp=7", m.emu_time); end
    #1 __emu_rst = 1'b1;
    #1;
    checks++; if (m.emu_time !== 40'd0) begin failures++; $display("FAIL arst_time got=%0d exp=0", m.emu_time); end
    checks++; if (m.__emu_dt !== DW'(0)) begin failures++; $display("FAIL arst_dt got=%0d exp=0", m.__emu_dt); end
    #1 __emu_rst = 1'b0;
    tick();
    checks++; if (m.emu_time !== 40'd7) begin failures++; $display("FAIL arst_post_time got=%0d exp=7", m.emu_time); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_min_grant();
    test_dt_max();
    test_stop_at();
    test_pause();
    test_single_step();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
